// File: rtl/sqrt_cop_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : sqrt_cop_arbiter_if
// Brief   : Requester, response and core-side signals of the sqrt arbiter.
// Revision: 1.0
// ============================================================================
interface sqrt_cop_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int RES_W   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_operand;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [RES_W-1:0]          rsp_result;
    logic                      rsp_error;
    logic                      core_start;
    logic [DATA_W-1:0]         core_operand;
    logic                      core_done;
    logic [RES_W-1:0]          core_result;
    logic                      core_abort;
    logic [ID_W-1:0]           grant_id;
    logic                      busy;

    // master: the arbiter itself; slave: requesters plus the sqrt core
    modport master (
        input  req_valid, req_operand, rsp_ready, core_done, core_result,
        output req_ready, rsp_valid, rsp_result, rsp_error, core_start,
               core_operand, core_abort, grant_id, busy
    );
    modport slave (
        output req_valid, req_operand, rsp_ready, core_done, core_result,
        input  req_ready, rsp_valid, rsp_result, rsp_error, core_start,
               core_operand, core_abort, grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/sqrt_cop_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sqrt_cop_arbiter
// Brief   : Round-robin sharing of one iterative sqrt core with watchdog abort.
// Revision: 1.0
// ============================================================================
module sqrt_cop_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              ACLK,
    input  logic              ARESET,
    sqrt_cop_arbiter_if.master bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]    C_WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [NUM_REQ-1:0] C_ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [WD_W-1:0]     r_watchdog;
    logic [DATA_W-1:0]   r_core_operand;
    logic                r_core_start;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic [RES_W-1:0]    r_rsp_result;
    logic                r_rsp_error;
    logic                r_busy;

    logic                w_found;
    logic [ID_W-1:0]     w_winner;
    int                  w_idx;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic                w_timeout;

    // Search starts just past the last owner so every requester gets a turn
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = (int'(r_rr_ptr) + off) % NUM_REQ;
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(w_idx);
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == S_IDLE && w_found && !ARESET) begin
            w_req_ready[w_winner] = 1'b1;
        end
    end

    // A done arriving on the last watchdog cycle takes precedence over abort
    assign w_timeout = (r_state == S_WAIT) && (r_watchdog == C_WD_LAST) && !bus.core_done;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state        <= S_IDLE;
            r_rr_ptr       <= ID_W'(NUM_REQ - 1);
            r_grant_id     <= '0;
            r_watchdog     <= '0;
            r_core_operand <= '0;
            r_core_start   <= 1'b0;
            r_rsp_valid    <= '0;
            r_rsp_result   <= '0;
            r_rsp_error    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_core_operand <= bus.req_operand[w_winner*DATA_W +: DATA_W];
                        r_grant_id     <= w_winner;
                        r_core_start   <= 1'b1;
                        r_busy         <= 1'b1;
                        r_state        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_watchdog <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_watchdog <= r_watchdog + 1'b1;
                    if (bus.core_done) begin
                        r_rsp_result <= bus.core_result;
                        r_rsp_error  <= 1'b0;
                        r_rsp_valid  <= C_ONE << r_grant_id;
                        r_state      <= S_RESP;
                    end else if (r_watchdog == C_WD_LAST) begin
                        r_rsp_result <= '0;
                        r_rsp_error  <= 1'b1;
                        r_rsp_valid  <= C_ONE << r_grant_id;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready[r_grant_id]) begin
                        r_rr_ptr    <= r_grant_id;
                        r_rsp_valid <= '0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_result   = r_rsp_result;
    assign bus.rsp_error    = r_rsp_error;
    assign bus.core_start   = r_core_start;
    assign bus.core_operand = r_core_operand;
    assign bus.core_abort   = w_timeout;
    assign bus.grant_id     = r_grant_id;
    assign bus.busy         = r_busy;

endmodule
`default_nettype wire
